// File: rtl/csr_arbiter.sv
// csr_arbiter: shares the single CSR file request port between NREQ requesters.
// A winner is chosen in IDLE and keeps the grant for the whole read/commit
// transaction. A commit that lands on an exception/return effect is dropped
// by the CSR file, so the transaction is replayed from its read phase. The
// response is routed back to the granted requester only.
module csr_arbiter #(
    parameter int NREQ        = 2,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   m_valid,
    input  logic [NREQ*12-1:0] m_addr,
    input  logic [NREQ*2-1:0] m_op,
    input  logic [NREQ*32-1:0] m_wdata,
    output logic [NREQ-1:0]   m_ready,
    output logic [31:0]       m_rdata,
    output logic              m_exists,
    output logic              csr_valid,
    output logic [11:0]       csr_addr,
    output logic [1:0]        csr_op,
    output logic [31:0]       csr_wdata,
    input  logic              csr_ready,
    input  logic [31:0]       csr_rdata,
    input  logic              csr_exists,
    input  logic              eff_hold
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RETRY = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   grant_nxt;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   rr_ptr_nxt;

    logic [11:0]     sel_addr;
    logic [1:0]      sel_op;
    logic [31:0]     sel_wdata;

    // Winner selection. Round-robin searches upward from the requester after
    // the last one served, wrapping at NREQ-1; fixed priority ignores the
    // pointer and takes the lowest valid index.
    function automatic logic [GW-1:0] pick(input logic [NREQ-1:0] req,
                                           input logic [GW-1:0]   ptr);
        logic [GW-1:0] win;
        logic          found;
        int            idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        if (ROUND_ROBIN) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(ptr) + k) % NREQ;
                if (!found && req[idx]) begin
                    win   = GW'(idx);
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req[k]) begin
                    win   = GW'(k);
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

    // State, grant and round-robin pointer registers; reset leaves the
    // pointer at the last requester so requester 0 is served first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= GW'(NREQ - 1);
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Payload of the granted requester, selected by a plain index compare.
    always_comb begin
        sel_addr  = '0;
        sel_op    = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(grant) == i) begin
                sel_addr  = m_addr[12*i +: 12];
                sel_op    = m_op[2*i +: 2];
                sel_wdata = m_wdata[32*i +: 32];
            end
        end
    end

    // Next-state logic and request/completion outputs. The CSR port only
    // carries a payload while a transaction is in ISSUE; a dropped commit
    // leaves the grant untouched so the replay goes to the same requester.
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        csr_valid  = 1'b0;
        csr_addr   = '0;
        csr_op     = '0;
        csr_wdata  = '0;
        m_ready    = '0;
        case (state)
            IDLE: begin
                if (|m_valid && !eff_hold) begin
                    grant_nxt = pick(m_valid, rr_ptr);
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                csr_valid = 1'b1;
                csr_addr  = sel_addr;
                csr_op    = sel_op;
                csr_wdata = sel_wdata;
                if (csr_ready) begin
                    if (!eff_hold) begin
                        m_ready[grant] = 1'b1;
                        rr_ptr_nxt     = grant;
                        state_nxt      = IDLE;
                    end else begin
                        state_nxt = RETRY;
                    end
                end
            end
            RETRY: begin
                // One idle cycle returns the CSR file to its read phase.
                state_nxt = ISSUE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Read data and exists flag pass straight through; they only mean
    // something while a completion pulse is high.
    assign m_rdata  = csr_rdata;
    assign m_exists = csr_exists;

endmodule

// File: tb/tb_csr_arbiter.sv
// tb_csr_arbiter: directed scoreboard bench. Instance 0 is round-robin,
// instance 1 fixed priority. A small CSR file model answers in the second
// cycle of csr_valid and echoes {addr, op, wdata[17:0]} as read data, so the
// returned data also proves the payload mux picked the right requester.
module tb_csr_arbiter;

    localparam logic [31:0] EXP0 = 32'h3414_0000; // {12'h341, 2'd1, 18'h00000}
    localparam logic [31:0] EXP1 = 32'hF14A_A5A5; // {12'hF14, 2'd2, 18'h2A5A5}

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] m_addr;
    logic [3:0]  m_op;
    logic [63:0] m_wdata;
    logic        eff_hold;

    logic [1:0]  mv  [2];
    logic [1:0]  rdy [2];
    logic [31:0] rd  [2];
    logic        ex  [2];
    logic        cv  [2];
    logic [11:0] ca  [2];
    logic [1:0]  co  [2];
    logic [31:0] cw  [2];
    logic        cr  [2];
    logic [31:0] crd [2];
    logic        cex [2];
    logic        ph  [2];
    logic [1:0]  rdy_q [2];

    int cyc = 0;
    int base;
    int checks = 0;
    int errors = 0;
    int pend [2][2];

    typedef struct {
        int          req;
        logic [31:0] rdata;
        logic        exists;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    csr_arbiter #(.NREQ(2), .ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .rst(rst), .m_valid(mv[0]), .m_addr(m_addr), .m_op(m_op),
        .m_wdata(m_wdata), .m_ready(rdy[0]), .m_rdata(rd[0]), .m_exists(ex[0]),
        .csr_valid(cv[0]), .csr_addr(ca[0]), .csr_op(co[0]), .csr_wdata(cw[0]),
        .csr_ready(cr[0]), .csr_rdata(crd[0]), .csr_exists(cex[0]), .eff_hold(eff_hold)
    );

    csr_arbiter #(.NREQ(2), .ROUND_ROBIN(1'b0)) u_fp (
        .clk(clk), .rst(rst), .m_valid(mv[1]), .m_addr(m_addr), .m_op(m_op),
        .m_wdata(m_wdata), .m_ready(rdy[1]), .m_rdata(rd[1]), .m_exists(ex[1]),
        .csr_valid(cv[1]), .csr_addr(ca[1]), .csr_op(co[1]), .csr_wdata(cw[1]),
        .csr_ready(cr[1]), .csr_rdata(crd[1]), .csr_exists(cex[1]), .eff_hold(eff_hold)
    );

    // CSR file model: read phase on the first csr_valid cycle, commit on the next.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph[0] <= 1'b0;
            ph[1] <= 1'b0;
        end else begin
            ph[0] <= cv[0] & ~ph[0];
            ph[1] <= cv[1] & ~ph[1];
        end
    end

    assign cr[0]  = cv[0] & ph[0];
    assign cr[1]  = cv[1] & ph[1];
    assign crd[0] = {ca[0], co[0], cw[0][17:0]};
    assign crd[1] = {ca[1], co[1], cw[1][17:0]};
    assign cex[0] = ~ca[0][11];
    assign cex[1] = ~ca[1][11];

    // Cycle counter and last-cycle completion pulses for the requester models.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rdy_q[0] <= rdy[0];
        rdy_q[1] <= rdy[1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int d, input int req, input int at);
        exp_t e;
        e.req    = req;
        e.rdata  = (req == 1) ? EXP1 : EXP0;
        e.exists = (req == 1) ? 1'b0 : 1'b1;
        e.cyc    = at;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: every completion pulse pops one expected entry.
    task automatic mon_step();
        for (int d = 0; d < 2; d++) begin
            if (|rdy[d]) begin
                exp_t e;
                bit   have;
                have = 1'b0;
                if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                if (!have) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready dut%0d: got m_ready=%b, expected none (cycle %0d)",
                             d, rdy[d], cyc);
                end else begin
                    chk($sformatf("ready_onehot dut%0d", d), 32'(rdy[d]), 32'(2'b01 << e.req));
                    chk($sformatf("rdata dut%0d", d), rd[d], e.rdata);
                    chk($sformatf("exists dut%0d", d), 32'(ex[d]), 32'(e.exists));
                    if (e.cyc >= 0)
                        chk($sformatf("ready_cycle dut%0d", d), 32'(cyc), 32'(e.cyc));
                end
            end
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            mon_step();
        end
    endtask

    // Requester model: keep m_valid up until the pending count is served.
    task automatic step(input int d);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rdy_q[d][i] && pend[d][i] > 0) pend[d][i]--;
            mv[d][i] = (pend[d][i] > 0);
        end
    endtask

    task automatic start(input int d, input int p0, input int p1);
        @(posedge clk);
        #1;
        pend[d][0] = p0;
        pend[d][1] = p1;
        mv[d]      = {p1 > 0, p0 > 0};
        base       = cyc;
    endtask

    task automatic wait_done(input int d, input int limit);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < limit) begin
            step(d);
            n++;
            done = (pend[d][0] == 0) && (pend[d][1] == 0) && (qsize(d) == 0);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout dut%0d: pending %0d/%0d, queue %0d after %0d cycles",
                     d, pend[d][0], pend[d][1], qsize(d), limit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        eff_hold = 1'b0;
        mv[0]    = 2'b00;
        mv[1]    = 2'b00;
        m_addr   = {12'hF14, 12'h341};
        m_op     = {2'd2, 2'd1};
        m_wdata  = {32'h0002_A5A5, 32'h0000_0000};
        for (int d = 0; d < 2; d++) begin
            pend[d][0] = 0;
            pend[d][1] = 0;
        end
        fork
            monitor_loop();
        join_none

        // Reset state on both instances.
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_csr_valid dut%0d", d), 32'(cv[d]), 32'd0);
            chk($sformatf("rst_m_ready dut%0d", d), 32'(rdy[d]), 32'd0);
            chk($sformatf("rst_csr_addr dut%0d", d), 32'(ca[d]), 32'd0);
            chk($sformatf("rst_csr_op dut%0d", d), 32'(co[d]), 32'd0);
            chk($sformatf("rst_csr_wdata dut%0d", d), cw[d], 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Round-robin contention: grants 0,1,0,1 three cycles apart.
        start(0, 2, 2);
        push(0, 0, base + 2);
        push(0, 1, base + 5);
        push(0, 0, base + 8);
        push(0, 1, base + 11);
        wait_done(0, 40);

        // Fixed-priority contention: requester 0 three times, then requester 1.
        start(1, 3, 1);
        push(1, 0, base + 2);
        push(1, 0, base + 5);
        push(1, 0, base + 8);
        push(1, 1, base + 11);
        wait_done(1, 40);

        // Effect hold in IDLE for three cycles blocks arbitration only.
        start(0, 0, 1);
        eff_hold = 1'b1;
        step(0);
        chk("hold_idle_c1", 32'(cv[0]), 32'd0);
        step(0);
        chk("hold_idle_c2", 32'(cv[0]), 32'd0);
        step(0);
        chk("hold_idle_c3", 32'(cv[0]), 32'd0);
        eff_hold = 1'b0;
        push(0, 1, base + 5);
        step(0);
        chk("hold_issue_valid", 32'(cv[0]), 32'd1);
        chk("hold_issue_addr", 32'(ca[0]), 32'h0000_0F14);
        wait_done(0, 20);

        // Effect collision in the commit cycle: drop, one idle cycle, replay.
        start(0, 1, 0);
        push(0, 0, -1);
        step(0);
        chk("coll_read_valid", 32'(cv[0]), 32'd1);
        chk("coll_read_ready", 32'(cr[0]), 32'd0);
        step(0);
        chk("coll_commit_ready", 32'(cr[0]), 32'd1);
        eff_hold = 1'b1;
        #1;
        chk("coll_no_m_ready", 32'(rdy[0]), 32'd0);
        step(0);
        eff_hold = 1'b0;
        chk("coll_retry_gap", 32'(cv[0]), 32'd0);
        step(0);
        chk("coll_reissue", 32'(cv[0]), 32'd1);
        wait_done(0, 20);

        // Single read: csr_valid one cycle after the request, m_ready one after that.
        start(0, 1, 0);
        push(0, 0, base + 2);
        chk("single_idle", 32'(cv[0]), 32'd0);
        step(0);
        chk("single_valid", 32'(cv[0]), 32'd1);
        chk("single_addr", 32'(ca[0]), 32'h0000_0341);
        chk("single_op", 32'(co[0]), 32'd1);
        chk("single_wdata", cw[0], 32'd0);
        wait_done(0, 20);

        // Reset while ISSUE is active: pointer was 0, so requester 1 holds the grant.
        start(0, 1, 1);
        step(0);
        chk("rst_issue_valid", 32'(cv[0]), 32'd1);
        chk("rst_issue_addr", 32'(ca[0]), 32'h0000_0F14);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_csr_valid", 32'(cv[0]), 32'd0);
        chk("rst_mid_m_ready", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(0, 0, cyc + 2);
        push(0, 1, cyc + 5);
        wait_done(0, 40);

        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
